// File: rtl/uart_pkg.sv
// Package: uart_pkg
// Definitions shared by the UART transmitter and receiver.
// - uart_state_t : frame sequencing states (IDLE, START, DATA, PARITY, STOP)
// - DATA_BITS    : number of data bits per frame
// - START_LVL    : line level during the start bit
// - STOP_LVL     : line level during the stop bit and while idle
// - calc_parity  : parity bit for a byte. The receiver's check uses the same
//                  function, so both sides always agree on the rule.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_parity_if.sv
// Interface: uart_tx_parity_if
// Byte handshake and serial line of the UART transmitter.
// Handshake: a byte moves when tx_valid and tx_ready are both high at a rising
// clock edge. tx_data only has to be stable at that edge. A tx_valid that is
// high while tx_ready is low is dropped, not remembered.
// - tx_data  : byte to send (master -> slave)
// - tx_valid : send request (master -> slave)
// - tx_ready : transmitter idle, accepts a byte this cycle (slave -> master)
// - tx_busy  : frame in progress, start through stop (slave -> master)
// - tx_done  : one-cycle pulse on the last cycle of the stop bit (slave -> master)
// - uart_tx  : serial line, idles high (slave -> master)
interface uart_tx_parity_if;

    logic [uart_pkg::DATA_BITS-1:0] tx_data;
    logic                           tx_valid;
    logic                           tx_ready;
    logic                           tx_busy;
    logic                           tx_done;
    logic                           uart_tx;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_busy,
        input  tx_done,
        input  uart_tx
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_busy,
        output tx_done,
        output uart_tx
    );

endinterface

// File: rtl/uart_baud_counter.sv
// Module: uart_baud_counter
// Bit-period timer shared by the UART transmitter and receiver. It counts
// 0..CLKS_PER_BIT-1 while enabled and never goes past CLKS_PER_BIT-1.
// Ports:
// - clk    : system clock, rising edge
// - reset  : synchronous, active-high
// - clear  : restart the count at 0 (used on every state change)
// - enable : count this cycle
// - tick   : high on the terminal count (last cycle of a bit period)
// - count  : current count, so the owner can act ahead of the terminal count
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 5208,
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic          tick,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/uart_tx_parity.sv
// Module: uart_tx_parity
// UART transmitter. It takes one byte per handshake and sends the frame
// start(0), 8 data bits LSB first, optional parity bit, stop(1).
// Parameters:
// - CLKS_PER_BIT : clocks per serial bit, 2..65535
// - PARITY_EN    : 1 inserts a parity bit after the data bits
// - PARITY_ODD   : 0 selects even parity, 1 selects odd parity
// Ports:
// - clk      : system clock, rising edge
// - reset    : synchronous, active-high. It wins over every input.
// - txIf     : slave side of uart_tx_parity_if (tx_data/valid/ready, status, uart_tx)
// - stateDbg : current FSM state, for observation only
module uart_tx_parity
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter bit PARITY_EN    = 1'b1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_parity_if.slave   txIf,
    output uart_state_t       stateDbg
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    // tx_done is registered. It is set one count before the stop bit's
    // terminal count so that the pulse lines up with the last STOP cycle.
    localparam logic [CW-1:0] NEAR_LAST = CW'(CLKS_PER_BIT - 2);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    uart_state_t          state;
    uart_state_t          stateNext;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shregNext;
    logic                 parityReg;
    logic [2:0]           bitIdx;
    logic                 line;
    logic                 lineNext;
    logic                 busy;
    logic                 done;
    logic                 doneNext;
    logic                 txReady;
    logic                 accept;
    logic                 tick;
    logic                 baudClear;
    logic                 baudEnable;
    logic [CW-1:0]        baudCount;

    // tx_ready is the only combinational output. Reset masks it at once, so
    // no byte can be accepted while reset is high.
    assign txReady = (state == IDLE) && !reset;
    assign accept  = txIf.tx_valid && txReady;

    // The bit timer restarts on every state change and stays at 0 while idle.
    assign baudClear  = (stateNext != state);
    assign baudEnable = (state != IDLE);

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (baudClear),
        .enable(baudEnable),
        .tick  (tick),
        .count (baudCount)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = START;
            START:   if (tick) stateNext = DATA;
            DATA:    if (tick && (bitIdx == LAST_BIT)) stateNext = PARITY_EN ? PARITY : STOP;
            PARITY:  if (tick) stateNext = STOP;
            STOP:    if (tick) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and the shifter.
    always_comb begin
        shregNext = shreg;
        if (accept) begin
            shregNext = txIf.tx_data;
        end else if ((state == DATA) && tick) begin
            shregNext = shreg >> 1;
        end

        lineNext = STOP_LVL;
        case (stateNext)
            IDLE:    lineNext = STOP_LVL;
            START:   lineNext = START_LVL;
            DATA:    lineNext = shregNext[0];
            PARITY:  lineNext = parityReg;
            STOP:    lineNext = STOP_LVL;
            default: lineNext = STOP_LVL;
        endcase

        doneNext = (state == STOP) && (baudCount == NEAR_LAST);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            parityReg <= 1'b0;
            bitIdx    <= '0;
            line      <= STOP_LVL;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            shreg <= shregNext;
            // Parity is taken from the byte at the accepting edge, so later
            // changes on tx_data cannot affect the frame in flight.
            if (accept) begin
                parityReg <= calc_parity(txIf.tx_data, PARITY_ODD);
            end
            if ((state == DATA) && tick) begin
                bitIdx <= bitIdx + 3'd1;
            end else if (state != DATA) begin
                bitIdx <= '0;
            end
            line <= lineNext;
            busy <= (stateNext != IDLE);
            done <= doneNext;
        end
    end

    assign txIf.tx_ready = txReady;
    assign txIf.tx_busy  = busy;
    assign txIf.tx_done  = done;
    assign txIf.uart_tx  = line;
    assign stateDbg      = state;

endmodule

// File: tb/tb_uart_tx_parity.sv
// Testbench: tb_uart_tx_parity
// Three transmitters with short bit periods cover the parity variants:
//   sel 0: CLKS_PER_BIT=4, even parity
//   sel 1: CLKS_PER_BIT=3, odd parity
//   sel 2: CLKS_PER_BIT=2, no parity
// One shared driver sends to the transmitter picked by sel. Frames are
// compared cycle by cycle against a line model built from the frame rules.
module tb_uart_tx_parity;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] drvData = 8'h00;
    logic       drvValid = 1'b0;
    int         sel = 0;

    int nChecks = 0;
    int nPass = 0;

    int cpbTab[3] = '{4, 3, 2};
    int peTab[3]  = '{1, 1, 0};
    int poTab[3]  = '{0, 1, 0};

    uart_tx_parity_if if0 ();
    uart_tx_parity_if if1 ();
    uart_tx_parity_if if2 ();

    uart_pkg::uart_state_t st0, st1, st2;

    logic mReady, mBusy, mDone, mLine;

    always #5 clk = ~clk;

    assign if0.tx_data  = drvData;
    assign if1.tx_data  = drvData;
    assign if2.tx_data  = drvData;
    assign if0.tx_valid = drvValid && (sel == 0);
    assign if1.tx_valid = drvValid && (sel == 1);
    assign if2.tx_valid = drvValid && (sel == 2);

    uart_tx_parity #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u0 (
        .clk(clk), .reset(reset), .txIf(if0), .stateDbg(st0));
    uart_tx_parity #(.CLKS_PER_BIT(3), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u1 (
        .clk(clk), .reset(reset), .txIf(if1), .stateDbg(st1));
    uart_tx_parity #(.CLKS_PER_BIT(2), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u2 (
        .clk(clk), .reset(reset), .txIf(if2), .stateDbg(st2));

    always_comb begin
        mReady = if0.tx_ready;
        mBusy  = if0.tx_busy;
        mDone  = if0.tx_done;
        mLine  = if0.uart_tx;
        case (sel)
            1: begin
                mReady = if1.tx_ready; mBusy = if1.tx_busy;
                mDone  = if1.tx_done;  mLine = if1.uart_tx;
            end
            2: begin
                mReady = if2.tx_ready; mBusy = if2.tx_busy;
                mDone  = if2.tx_done;  mLine = if2.uart_tx;
            end
            default: ;
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Handshake on transmitter s. Returns at the first falling edge after
    // the accepting edge (frame cycle 0) with tx_valid released.
    task automatic send_byte(input int s, input logic [7:0] d);
        int w;
        @(negedge clk);
        sel = s;
        #0;
        w = 0;
        while (!mReady && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) check("ready_timeout", 0, 1);
        drvData  = d;
        drvValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drvValid = 1'b0;
    endtask

    // Called at frame cycle 0. Compares the line, busy and done against the
    // frame model. expPar/expBits are the table values (-1: no parity check).
    // On return the bench sits at the first cycle after the frame.
    task automatic check_frame(input int s, input logic [7:0] d, input int expPar, input int expBits);
        logic expQ[$];
        int   cpb, total, lineBad, busyBad, doneCnt, doneAt, parObs;
        cpb = cpbTab[s];
        expQ.push_back(1'b0);
        for (int i = 0; i < 8; i++) expQ.push_back(d[i]);
        if (peTab[s] == 1) expQ.push_back(logic'(($countones(d) % 2) ^ poTab[s]));
        expQ.push_back(1'b1);
        total   = expQ.size() * cpb;
        lineBad = 0; busyBad = 0; doneCnt = 0; doneAt = -1; parObs = -1;
        for (int c = 0; c < total; c++) begin
            if (mLine !== expQ[c / cpb]) begin
                if (lineBad == 0)
                    $display("FAIL line_first c=%0d: got %0b, expected %0b", c, mLine, expQ[c / cpb]);
                lineBad++;
            end
            if (mBusy !== 1'b1) busyBad++;
            if (mDone === 1'b1) begin
                doneCnt++;
                doneAt = c;
            end
            if (c == 9 * cpb + cpb / 2) parObs = int'(mLine);
            @(negedge clk);
        end
        check("line_mismatch_cycles", lineBad, 0);
        check("busy_low_cycles", busyBad, 0);
        check("done_pulses", doneCnt, 1);
        check("done_cycle", doneAt, expBits * cpb - 1);
        if (expPar >= 0) check("parity_bit", parObs, expPar);
        check("ready_after", int'(mReady), 1);
        check("busy_after", int'(mBusy), 0);
        check("line_after", int'(mLine), 1);
        check("done_after", int'(mDone), 0);
    endtask

    task automatic run_frame(input int s, input logic [7:0] d, input int expPar, input int expBits);
        send_byte(s, d);
        check_frame(s, d, expPar, expBits);
    endtask

    typedef struct {
        int         sel;
        logic [7:0] data;
        int         expPar;
        int         expBits;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int cnt;

        vecs[0] = '{0, 8'h06, 0, 11};
        vecs[1] = '{0, 8'h07, 1, 11};
        vecs[2] = '{0, 8'hFF, 0, 11};
        vecs[3] = '{1, 8'h07, 0, 11};
        vecs[4] = '{1, 8'h00, 1, 11};
        vecs[5] = '{2, 8'h06, -1, 10};
        vecs[6] = '{2, 8'hB1, -1, 10};

        // Reset held for three cycles with no request
        repeat (3) begin
            @(negedge clk);
            check("rst_line", int'(if0.uart_tx & if1.uart_tx & if2.uart_tx), 1);
            check("rst_busy", int'(if0.tx_busy | if1.tx_busy | if2.tx_busy), 0);
            check("rst_done", int'(if0.tx_done | if1.tx_done | if2.tx_done), 0);
            check("rst_ready_masked", int'(if0.tx_ready), 0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", int'(if0.tx_ready & if1.tx_ready & if2.tx_ready), 1);
        check("idle_state0", int'(st0 == uart_pkg::IDLE), 1);
        check("idle_state12", int'((st1 == uart_pkg::IDLE) && (st2 == uart_pkg::IDLE)), 1);

        // Directed vectors
        for (int i = 0; i < 7; i++) run_frame(vecs[i].sel, vecs[i].data, vecs[i].expPar, vecs[i].expBits);

        // tx_valid held high across two bytes
        @(negedge clk);
        sel = 0;
        drvData = 8'hA5;
        drvValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drvData = 8'h3C;
        check_frame(0, 8'hA5, 0, 11);
        @(negedge clk);
        drvValid = 1'b0;
        check("b2b_second_busy", int'(mBusy), 1);
        check_frame(0, 8'h3C, 0, 11);

        // Requests while busy are dropped
        send_byte(0, 8'h07);
        fork
            check_frame(0, 8'h07, 1, 11);
            begin
                repeat (6) @(negedge clk);
                drvData = 8'hEE;
                drvValid = 1'b1;
                @(negedge clk);
                drvValid = 1'b0;
                repeat (10) @(negedge clk);
                drvValid = 1'b1;
                @(negedge clk);
                drvValid = 1'b0;
            end
        join
        cnt = 0;
        repeat (6) begin
            if (mBusy !== 1'b0) cnt++;
            @(negedge clk);
        end
        check("not_queued", cnt, 0);

        // Reset in the middle of data bit 4 of 0x5A
        send_byte(0, 8'h5A);
        repeat (21) @(negedge clk);
        check("pre_reset_line_bit4", int'(mLine), 1);
        check("pre_reset_busy", int'(mBusy), 1);
        reset = 1'b1;
        #1;
        check("ready_in_reset", int'(mReady), 0);
        @(negedge clk);
        check("post_reset_line", int'(mLine), 1);
        check("post_reset_busy", int'(mBusy), 0);
        check("post_reset_done", int'(mDone), 0);
        reset = 1'b0;
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (mDone !== 1'b0 || mBusy !== 1'b0 || mLine !== 1'b1) cnt++;
        end
        check("dropped_frame_quiet", cnt, 0);
        run_frame(0, 8'h5A, 0, 11);

        // Random bytes on random transmitters
        repeat (12) begin
            int s;
            logic [7:0] d;
            s = $urandom_range(0, 2);
            d = 8'($urandom_range(0, 255));
            run_frame(s, d, -1, (peTab[s] == 1) ? 11 : 10);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
